// File: rtl/rv32i_mem_access.sv
// Load/store and writeback stage: passes ALU results to the register file and runs
// Avalon-MM data-bus loads/stores, stalling upstream while an access is in flight.
module rv32i_mem_access #(
  parameter logic [31:0] ADDR_RESET_VAL = 32'h0000_0000,
  parameter int          MEM_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ex_valid,
  input  logic                 ex_load,
  input  logic                 ex_store,
  input  logic [2:0]           ex_funct3,
  input  logic [31:0]          ex_addr,
  input  logic [31:0]          ex_wdata,
  input  logic [4:0]           ex_rd_idx,
  input  logic [31:0]          ex_rd_val,
  output logic [4:0]           rd_idx,
  output logic [31:0]          new_rd,
  output logic                 stall,
  output logic                 misaligned,
  output logic [31:0]          misaligned_addr,
  output logic [31:0]          mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [MEM_WIDTH-1:0] mem_wdata,
  output logic [3:0]           mem_be,
  input  logic [MEM_WIDTH-1:0] mem_rdata,
  input  logic                 mem_waitreq,
  input  logic                 mem_rdvalid
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t      r_state;
  logic        r_is_load;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [4:0]  r_rd_idx;

  logic        w_mem_op;
  logic        w_misaligned;

  assign w_mem_op     = ex_load | ex_store;
  assign w_misaligned = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                        ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));

  // stall is a pure decode of the state register, so reset drops it at once
  assign stall = (r_state != S_IDLE);

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{off, 3'b000} +: 8];
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b100:  fmt_load = {24'h0, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b101:  fmt_load = {16'h0, h};
      default: fmt_load = d;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_is_load       <= 1'b0;
      r_funct3        <= 3'b000;
      r_off           <= 2'b00;
      r_rd_idx        <= 5'd0;
      rd_idx          <= 5'd0;
      new_rd          <= 32'h0;
      misaligned      <= 1'b0;
      misaligned_addr <= ADDR_RESET_VAL;
      mem_addr        <= ADDR_RESET_VAL;
      mem_rd          <= 1'b0;
      mem_wr          <= 1'b0;
      mem_wdata       <= '0;
      mem_be          <= 4'b0000;
    end else begin
      rd_idx     <= 5'd0;
      misaligned <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ex_valid && !w_mem_op) begin
            rd_idx <= ex_rd_idx;
            new_rd <= ex_rd_val;
          end else if (ex_valid && w_misaligned) begin
            misaligned      <= 1'b1;
            misaligned_addr <= ex_addr;
          end else if (ex_valid) begin
            mem_addr  <= {ex_addr[31:2], 2'b00};
            mem_rd    <= ex_load;
            mem_wr    <= ex_store;
            r_is_load <= ex_load;
            r_funct3  <= ex_funct3;
            r_off     <= ex_addr[1:0];
            r_rd_idx  <= ex_rd_idx;
            r_state   <= S_REQ;
            if (ex_load) begin
              mem_be <= 4'b1111;
            end else begin
              case (ex_funct3[1:0])
                2'b00: begin
                  mem_be    <= 4'b0001 << ex_addr[1:0];
                  mem_wdata <= {4{ex_wdata[7:0]}};
                end
                2'b01: begin
                  mem_be    <= ex_addr[1] ? 4'b1100 : 4'b0011;
                  mem_wdata <= {2{ex_wdata[15:0]}};
                end
                default: begin
                  mem_be    <= 4'b1111;
                  mem_wdata <= ex_wdata;
                end
              endcase
            end
          end
        end
        S_REQ: begin
          if (!mem_waitreq) begin
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            r_state <= r_is_load ? S_RESP : S_IDLE;
          end
        end
        S_RESP: begin
          if (mem_rdvalid) begin
            rd_idx  <= r_rd_idx;
            new_rd  <= fmt_load(r_funct3, r_off, mem_rdata);
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mem_access.sv
// Directed bench for rv32i_mem_access: pass-through, loads, stores, misalignment and reset.
module tb_rv32i_mem_access;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid, ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata, ex_rd_val;
  logic [4:0]  ex_rd_idx;
  logic [4:0]  rd_idx;
  logic [31:0] new_rd;
  logic        stall, misaligned;
  logic [31:0] misaligned_addr, mem_addr;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_waitreq, mem_rdvalid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32i_mem_access #(.ADDR_RESET_VAL(32'h0000_0000), .MEM_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store), .ex_funct3(ex_funct3),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd_idx(ex_rd_idx), .ex_rd_val(ex_rd_val),
    .rd_idx(rd_idx), .new_rd(new_rd), .stall(stall), .misaligned(misaligned),
    .misaligned_addr(misaligned_addr), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_waitreq(mem_waitreq), .mem_rdvalid(mem_rdvalid)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rv);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_addr = a; ex_wdata = wd; ex_rd_idx = rd; ex_rd_val = rv;
  endtask

  // Runs one load with zero waitrequest and rdvalid one cycle after the request completes.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                         input logic [31:0] rdata, output int stall_cnt, output int rd_cnt,
                         output logic [31:0] got_addr, output logic [4:0] got_idx,
                         output logic [31:0] got_val);
    issue(1'b1, 1'b0, f3, a, 32'h0, rd, 32'h0);
    mem_rdata = rdata; mem_waitreq = 1'b0; mem_rdvalid = 1'b0;
    tick;
    got_addr = mem_addr;
    stall_cnt = 0; rd_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (!stall) break;
      stall_cnt++;
      if (mem_rd) rd_cnt++;
      mem_rdvalid = !mem_rd;
      tick;
    end
    got_idx = rd_idx; got_val = new_rd;
    ex_valid = 1'b0; ex_load = 1'b0; mem_rdvalid = 1'b0;
    $display("txn load f3=%b addr=%h -> rd_idx=%0d new_rd=%h stall=%0d", f3, a, got_idx, got_val, stall_cnt);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick; tick;
    n_checks++; if (stall !== 1'b0 || rd_idx !== 5'd0 || new_rd !== 32'h0 || misaligned !== 1'b0) begin
      n_fail++; $display("FAIL reset_core: stall=%b rd_idx=%0d new_rd=%h mis=%b want 0", stall, rd_idx, new_rd, misaligned); end
    n_checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || mem_be !== 4'b0 || mem_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus: rd=%b wr=%b be=%b wdata=%h want 0", mem_rd, mem_wr, mem_be, mem_wdata); end
    n_checks++; if (mem_addr !== 32'h0 || misaligned_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_addr: mem_addr=%h mis_addr=%h want 0", mem_addr, misaligned_addr); end
    @(negedge clk); reset_n = 1'b1;
    tick;
    $display("txn reset released");
  endtask

  task automatic test_pass_through;
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd5, 32'h1234_5678);
    tick;
    n_checks++; if (rd_idx !== 5'd5 || new_rd !== 32'h1234_5678) begin
      n_fail++; $display("FAIL pt_result: rd_idx=%0d new_rd=%h want 5/12345678", rd_idx, new_rd); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL pt_stall: got %b want 0", stall); end
    ex_valid = 1'b0;
    tick;
    n_checks++; if (rd_idx !== 5'd0) begin n_fail++; $display("FAIL pt_idle_rd: got %0d want 0", rd_idx); end
    $display("txn pass-through rd=5 val=12345678");
  endtask

  task automatic test_back_to_back;
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd3, 32'hDEAD_0003);
    tick;
    n_checks++; if (rd_idx !== 5'd3 || new_rd !== 32'hDEAD_0003) begin
      n_fail++; $display("FAIL b2b_first: rd_idx=%0d new_rd=%h want 3/DEAD0003", rd_idx, new_rd); end
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 32'h5555_5555);
    tick;
    n_checks++; if (rd_idx !== 5'd0) begin n_fail++; $display("FAIL b2b_x0: rd_idx=%0d want 0", rd_idx); end
    ex_valid = 1'b0;
    tick;
    $display("txn back-to-back pass-through rd=3 then rd=0");
  endtask

  task automatic test_load_byte;
    int sc, rc; logic [31:0] ga, gv; logic [4:0] gi;
    do_load(3'b000, 32'h1003, 5'd7, 32'h80FF_FFFF, sc, rc, ga, gi, gv);
    n_checks++; if (ga !== 32'h1000) begin n_fail++; $display("FAIL lb_addr: got %h want 00001000", ga); end
    n_checks++; if (sc != 2 || rc != 1) begin n_fail++; $display("FAIL lb_timing: stall=%0d rd=%0d want 2/1", sc, rc); end
    n_checks++; if (gi !== 5'd7 || gv !== 32'hFFFF_FF80) begin
      n_fail++; $display("FAIL lb_data: rd_idx=%0d new_rd=%h want 7/FFFFFF80", gi, gv); end
    do_load(3'b100, 32'h1003, 5'd7, 32'h80FF_FFFF, sc, rc, ga, gi, gv);
    n_checks++; if (gi !== 5'd7 || gv !== 32'h0000_0080) begin
      n_fail++; $display("FAIL lbu_data: rd_idx=%0d new_rd=%h want 7/00000080", gi, gv); end
    tick;
    n_checks++; if (rd_idx !== 5'd0) begin n_fail++; $display("FAIL lb_after: rd_idx=%0d want 0", rd_idx); end
  endtask

  task automatic test_load_half;
    int sc, rc; logic [31:0] ga, gv; logic [4:0] gi;
    do_load(3'b001, 32'h5002, 5'd12, 32'h8001_1234, sc, rc, ga, gi, gv);
    n_checks++; if (ga !== 32'h5000 || gi !== 5'd12 || gv !== 32'hFFFF_8001) begin
      n_fail++; $display("FAIL lh_data: addr=%h rd_idx=%0d new_rd=%h want 5000/12/FFFF8001", ga, gi, gv); end
    do_load(3'b101, 32'h5000, 5'd12, 32'h8001_9234, sc, rc, ga, gi, gv);
    n_checks++; if (gv !== 32'h0000_9234) begin n_fail++; $display("FAIL lhu_data: got %h want 00009234", gv); end
  endtask

  task automatic test_store_half_wait;
    int wr_cnt = 0; int st_cnt = 0; int bad_rd = 0;
    issue(1'b0, 1'b1, 3'b001, 32'h2002, 32'hAAAA_BEEF, 5'd9, 32'h0);
    mem_waitreq = 1'b1;
    tick;
    n_checks++; if (mem_be !== 4'b1100 || mem_wdata !== 32'hBEEF_BEEF || mem_addr !== 32'h2000) begin
      n_fail++; $display("FAIL sh_bus: be=%b wdata=%h addr=%h want 1100/BEEFBEEF/2000", mem_be, mem_wdata, mem_addr); end
    for (int k = 0; k < 20; k++) begin
      if (!stall) break;
      st_cnt++;
      if (mem_wr) wr_cnt++;
      if (rd_idx !== 5'd0) bad_rd++;
      mem_waitreq = (k < 3);
      tick;
    end
    ex_valid = 1'b0; ex_store = 1'b0; mem_waitreq = 1'b0;
    n_checks++; if (wr_cnt != 4 || st_cnt != 4) begin
      n_fail++; $display("FAIL sh_wait: mem_wr=%0d stall=%0d want 4/4", wr_cnt, st_cnt); end
    n_checks++; if (bad_rd != 0 || rd_idx !== 5'd0 || mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL sh_end: bad_rd=%0d rd_idx=%0d mem_wr=%b want 0", bad_rd, rd_idx, mem_wr); end
    $display("txn store SH addr=2002 mem_wr cycles=%0d", wr_cnt);
  endtask

  task automatic test_store_byte;
    issue(1'b0, 1'b1, 3'b000, 32'h2006, 32'h1234_56A5, 5'd4, 32'h0);
    mem_waitreq = 1'b0;
    tick;
    n_checks++; if (mem_wr !== 1'b1 || mem_be !== 4'b0100 || mem_wdata !== 32'hA5A5_A5A5 || mem_addr !== 32'h2004) begin
      n_fail++; $display("FAIL sb_bus: wr=%b be=%b wdata=%h addr=%h want 1/0100/A5A5A5A5/2004", mem_wr, mem_be, mem_wdata, mem_addr); end
    tick;
    ex_valid = 1'b0; ex_store = 1'b0;
    n_checks++; if (mem_wr !== 1'b0 || stall !== 1'b0 || rd_idx !== 5'd0) begin
      n_fail++; $display("FAIL sb_done: wr=%b stall=%b rd_idx=%0d want 0/0/0", mem_wr, stall, rd_idx); end
    $display("txn store SB addr=2006");
  endtask

  task automatic test_misaligned;
    issue(1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 5'd6, 32'h0);
    tick;
    ex_valid = 1'b0; ex_load = 1'b0;
    n_checks++; if (misaligned !== 1'b1 || misaligned_addr !== 32'h3001) begin
      n_fail++; $display("FAIL mis_pulse: mis=%b addr=%h want 1/00003001", misaligned, misaligned_addr); end
    n_checks++; if (mem_rd !== 1'b0 || stall !== 1'b0 || rd_idx !== 5'd0) begin
      n_fail++; $display("FAIL mis_nobus: rd=%b stall=%b rd_idx=%0d want 0", mem_rd, stall, rd_idx); end
    tick;
    n_checks++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_one_cycle: got %b want 0", misaligned); end
    $display("txn misaligned LW addr=3001");
  endtask

  task automatic test_load_x0;
    int sc, rc; logic [31:0] ga, gv; logic [4:0] gi;
    do_load(3'b010, 32'h4000, 5'd0, 32'h1122_3344, sc, rc, ga, gi, gv);
    n_checks++; if (rc != 1 || sc != 2 || gi !== 5'd0) begin
      n_fail++; $display("FAIL lw_x0: rd_cycles=%0d stall=%0d rd_idx=%0d want 1/2/0", rc, sc, gi); end
  endtask

  task automatic test_reset_mid_access;
    int sc, rc; logic [31:0] ga, gv; logic [4:0] gi;
    issue(1'b1, 1'b0, 3'b010, 32'h6000, 32'h0, 5'd9, 32'h0);
    mem_waitreq = 1'b0; mem_rdvalid = 1'b0;
    tick;
    tick;
    n_checks++; if (stall !== 1'b1 || mem_rd !== 1'b0) begin
      n_fail++; $display("FAIL rst_resp_state: stall=%b mem_rd=%b want 1/0", stall, mem_rd); end
    ex_valid = 1'b0; ex_load = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL rst_async: stall=%b mem_rd=%b addr=%h want 0/0/0", stall, mem_rd, mem_addr); end
    @(negedge clk); reset_n = 1'b1;
    mem_rdata = 32'h7777_7777; mem_rdvalid = 1'b1;
    tick;
    mem_rdvalid = 1'b0;
    n_checks++; if (rd_idx !== 5'd0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL rst_stale_rdvalid: rd_idx=%0d stall=%b want 0/0", rd_idx, stall); end
    do_load(3'b010, 32'h6000, 5'd9, 32'hCAFE_F00D, sc, rc, ga, gi, gv);
    n_checks++; if (gi !== 5'd9 || gv !== 32'hCAFE_F00D || sc != 2) begin
      n_fail++; $display("FAIL rst_next_load: rd_idx=%0d new_rd=%h stall=%0d want 9/CAFEF00D/2", gi, gv, sc); end
  endtask

  initial begin
    reset_n = 1'b0;
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'b000;
    ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd_idx = 5'd0; ex_rd_val = 32'h0;
    mem_rdata = 32'h0; mem_waitreq = 1'b0; mem_rdvalid = 1'b0;
    test_reset;
    test_pass_through;
    test_back_to_back;
    test_load_byte;
    test_load_half;
    test_store_half_wait;
    test_store_byte;
    test_misaligned;
    test_load_x0;
    test_reset_mid_access;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
